map_scroll_controller: RTL and testbench

Frame-rate camera controller for the 240x160 GBA-style view into the 480x320 overworld map. Decodes WASD keycodes into Pokemon-style tile-locked steps and animates each step one pixel per frame. Drives the ScreenX/ScreenY window origin consumed by the colour mapper. Also supplies player facing, a walk flag and an animation phase for the sprite stage.

---
 rtl/map_scroll_controller_if.sv | 27 ++
 rtl/map_scroll_controller.sv | 188 ++++++++++++++++++
 tb/tb_map_scroll_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/map_scroll_controller_if.sv
// Camera bus between the keyboard/camera logic and its consumers.
//   keycode    : two USB HID keycodes, [7:0] primary, [15:8] secondary
//   ScreenX/Y  : window origin in map pixels
//   facing     : 00 down, 01 up, 10 left, 11 right
//   walking    : a step is in progress (including its completion frame)
//   anim_frame : walk animation phase
//   step_done  : one-frame pulse when a step completes
// master drives keycode; slave (the controller) drives the rest.
interface map_scroll_controller_if;
  logic [15:0] keycode;
  logic [9:0]  ScreenX;
  logic [9:0]  ScreenY;
  logic [1:0]  facing;
  logic        walking;
  logic [1:0]  anim_frame;
  logic        step_done;

  modport master (
    output keycode,
    input  ScreenX, ScreenY, facing, walking, anim_frame, step_done
  );

  modport slave (
    input  keycode,
    output ScreenX, ScreenY, facing, walking, anim_frame, step_done
  );
endinterface

// File: rtl/map_scroll_controller.sv
// Frame-rate camera controller: decodes WASD keycodes into tile-locked steps
// and animates each step STEP_PX pixels per frame.
// Ports:
//   frame_clk : frame-rate clock (vsync), rising-edge updates
//   Reset     : asynchronous, active-high reset
//   bus       : camera bus (slave side), see map_scroll_controller_if
module map_scroll_controller #(
  parameter int unsigned TILE     = 16,
  parameter int unsigned STEP_PX  = 1,
  parameter int unsigned X_MAX    = 240,
  parameter int unsigned Y_MAX    = 160,
  parameter int unsigned ANIM_DIV = 4
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  map_scroll_controller_if.slave bus
);

  localparam int unsigned POS_W  = 10;
  localparam int unsigned CMP_W  = POS_W + 1;
  localparam int unsigned CNT_W  = $clog2(TILE + 1);
  localparam int unsigned ANIM_W = $clog2(ANIM_DIV + 1);

  typedef enum logic [0:0] {IDLE, WALK} state_t;

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   screen_x_q, screen_x_d;
  logic [POS_W-1:0]   screen_y_q, screen_y_d;
  logic [1:0]         facing_q, facing_d;
  logic [1:0]         dir_q, dir_d;
  logic [CNT_W-1:0]   px_cnt_q, px_cnt_d;
  logic [ANIM_W-1:0]  anim_cnt_q, anim_cnt_d;
  logic [1:0]         anim_frame_q, anim_frame_d;
  logic               walking_q, walking_d;
  logic               step_done_q, step_done_d;

  logic               req_valid_c;
  logic [1:0]         req_dir_c;
  logic               req_legal_c;
  logic [1:0]         move_dir_c;
  logic [POS_W-1:0]   moved_x_c, moved_y_c;
  logic [CNT_W-1:0]   px_next_c;
  logic [ANIM_W-1:0]  anim_next_c;

  // {valid, dir} for one keycode byte
  function automatic logic [2:0] decode_key(input logic [7:0] k);
    case (k)
      8'h1A:   decode_key = {1'b1, DIR_UP};
      8'h16:   decode_key = {1'b1, DIR_DOWN};
      8'h04:   decode_key = {1'b1, DIR_LEFT};
      8'h07:   decode_key = {1'b1, DIR_RIGHT};
      default: decode_key = 3'b000;
    endcase
  endfunction

  // Request decode: primary byte wins, secondary only if primary is not a direction
  always_comb begin
    logic [2:0] pri_c;
    logic [2:0] sec_c;
    pri_c       = decode_key(bus.keycode[7:0]);
    sec_c       = decode_key(bus.keycode[15:8]);
    req_valid_c = pri_c[2] | sec_c[2];
    req_dir_c   = pri_c[2] ? pri_c[1:0] : sec_c[1:0];
  end

  // Bounds check in one extra bit so X_MAX/Y_MAX near the top never wraps
  always_comb begin
    req_legal_c = 1'b0;
    case (req_dir_c)
      DIR_LEFT:  req_legal_c = CMP_W'(screen_x_q) >= CMP_W'(TILE);
      DIR_RIGHT: req_legal_c = (CMP_W'(screen_x_q) + CMP_W'(TILE)) <= CMP_W'(X_MAX);
      DIR_UP:    req_legal_c = CMP_W'(screen_y_q) >= CMP_W'(TILE);
      default:   req_legal_c = (CMP_W'(screen_y_q) + CMP_W'(TILE)) <= CMP_W'(Y_MAX);
    endcase
  end

  // One-pixel-step position for whichever direction applies this frame
  always_comb begin
    move_dir_c = (state_q == IDLE) ? req_dir_c : dir_q;
    moved_x_c  = screen_x_q;
    moved_y_c  = screen_y_q;
    case (move_dir_c)
      DIR_LEFT:  moved_x_c = screen_x_q - POS_W'(STEP_PX);
      DIR_RIGHT: moved_x_c = screen_x_q + POS_W'(STEP_PX);
      DIR_UP:    moved_y_c = screen_y_q - POS_W'(STEP_PX);
      default:   moved_y_c = screen_y_q + POS_W'(STEP_PX);
    endcase
  end

  assign px_next_c   = px_cnt_q + CNT_W'(STEP_PX);
  assign anim_next_c = anim_cnt_q + ANIM_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    screen_x_d   = screen_x_q;
    screen_y_d   = screen_y_q;
    facing_d     = facing_q;
    dir_d        = dir_q;
    px_cnt_d     = px_cnt_q;
    anim_cnt_d   = anim_cnt_q;
    anim_frame_d = anim_frame_q;
    walking_d    = 1'b0;
    step_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_c) begin
          facing_d = req_dir_c;
          if (req_legal_c) begin
            dir_d        = req_dir_c;
            screen_x_d   = moved_x_c;
            screen_y_d   = moved_y_c;
            px_cnt_d     = CNT_W'(STEP_PX);
            // counter cleared, and this first walking frame already counts
            anim_cnt_d   = ANIM_W'(1);
            anim_frame_d = 2'd0;
            walking_d    = 1'b1;
            state_d      = WALK;
          end
        end
      end

      WALK: begin
        screen_x_d = moved_x_c;
        screen_y_d = moved_y_c;
        px_cnt_d   = px_next_c;
        // walking also covers the completion frame, alongside step_done
        walking_d  = 1'b1;
        if (anim_next_c == ANIM_W'(ANIM_DIV)) begin
          anim_cnt_d   = '0;
          anim_frame_d = anim_frame_q + 2'd1;
        end else begin
          anim_cnt_d   = anim_next_c;
        end
        if (px_next_c == CNT_W'(TILE)) begin
          step_done_d  = 1'b1;
          anim_frame_d = 2'd0;
          anim_cnt_d   = '0;
          px_cnt_d     = '0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      screen_x_q   <= '0;
      screen_y_q   <= '0;
      facing_q     <= DIR_DOWN;
      dir_q        <= DIR_DOWN;
      px_cnt_q     <= '0;
      anim_cnt_q   <= '0;
      anim_frame_q <= 2'd0;
      walking_q    <= 1'b0;
      step_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      screen_x_q   <= screen_x_d;
      screen_y_q   <= screen_y_d;
      facing_q     <= facing_d;
      dir_q        <= dir_d;
      px_cnt_q     <= px_cnt_d;
      anim_cnt_q   <= anim_cnt_d;
      anim_frame_q <= anim_frame_d;
      walking_q    <= walking_d;
      step_done_q  <= step_done_d;
    end
  end

  assign bus.ScreenX    = screen_x_q;
  assign bus.ScreenY    = screen_y_q;
  assign bus.facing     = facing_q;
  assign bus.walking    = walking_q;
  assign bus.anim_frame = anim_frame_q;
  assign bus.step_done  = step_done_q;

endmodule

// File: tb/tb_map_scroll_controller.sv
// Directed bench for map_scroll_controller with hand-computed expectations.
module tb_map_scroll_controller;

  logic frame_clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  map_scroll_controller_if bus ();

  map_scroll_controller dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one frame: active edge, then sample just after it
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge frame_clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_x"},    32'(bus.ScreenX),    32'd0);
    check_eq({tag, "_y"},    32'(bus.ScreenY),    32'd0);
    check_eq({tag, "_face"}, 32'(bus.facing),     32'd0);
    check_eq({tag, "_walk"}, 32'(bus.walking),    32'd0);
    check_eq({tag, "_anim"}, 32'(bus.anim_frame), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.step_done),  32'd0);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    Reset       = 1'b1;
    bus.keycode = 16'h0000;
    #2;
    check_reset_vals("rst_async");
    do_reset();
    check_reset_vals("rst");

    // single right step, edges 0..15
    bus.keycode = 16'h0007;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq($sformatf("d_x%0d", i),    32'(bus.ScreenX),    32'(i + 1));
      check_eq($sformatf("d_walk%0d", i), 32'(bus.walking),    32'd1);
      check_eq($sformatf("d_anim%0d", i), 32'(bus.anim_frame),
               (i == 15) ? 32'd0 : 32'(((i + 1) / 4) % 4));
      check_eq($sformatf("d_done%0d", i), 32'(bus.step_done),  (i == 15) ? 32'd1 : 32'd0);
    end
    check_eq("d_face", 32'(bus.facing), 32'd3);

    // held key: next step starts on edge 16
    tick();
    check_eq("hold_x16",    32'(bus.ScreenX),   32'd17);
    check_eq("hold_done16", 32'(bus.step_done), 32'd0);
    repeat (223) tick();
    check_eq("hold_x239",    32'(bus.ScreenX),   32'd240);
    check_eq("hold_done239", 32'(bus.step_done), 32'd1);
    tick();
    check_eq("edge_x",    32'(bus.ScreenX), 32'd240);
    check_eq("edge_walk", 32'(bus.walking), 32'd0);
    check_eq("edge_face", 32'(bus.facing),  32'd3);
    repeat (3) tick();
    check_eq("edge_x_late",    32'(bus.ScreenX),   32'd240);
    check_eq("edge_walk_late", 32'(bus.walking),   32'd0);
    check_eq("edge_done_late", 32'(bus.step_done), 32'd0);

    // turn in place at the top-left corner
    bus.keycode = 16'h0000;
    do_reset();
    bus.keycode = 16'h0004;
    tick();
    check_eq("blkA_face", 32'(bus.facing),    32'd2);
    check_eq("blkA_x",    32'(bus.ScreenX),   32'd0);
    check_eq("blkA_walk", 32'(bus.walking),   32'd0);
    check_eq("blkA_done", 32'(bus.step_done), 32'd0);
    bus.keycode = 16'h001A;
    tick();
    check_eq("blkW_face", 32'(bus.facing),    32'd1);
    check_eq("blkW_y",    32'(bus.ScreenY),   32'd0);
    check_eq("blkW_walk", 32'(bus.walking),   32'd0);
    check_eq("blkW_done", 32'(bus.step_done), 32'd0);

    // primary byte wins: move right one tile, then 16'h1A04 goes left
    bus.keycode = 16'h0007;
    repeat (16) tick();
    check_eq("pri_setup_x", 32'(bus.ScreenX), 32'd16);
    bus.keycode = 16'h1A04;
    tick();
    check_eq("pri_x0",   32'(bus.ScreenX), 32'd15);
    check_eq("pri_face", 32'(bus.facing),  32'd2);
    bus.keycode = 16'h0000;
    repeat (15) tick();
    check_eq("pri_x",    32'(bus.ScreenX),   32'd0);
    check_eq("pri_y",    32'(bus.ScreenY),   32'd0);
    check_eq("pri_done", 32'(bus.step_done), 32'd1);

    // non-direction primary: secondary S used
    bus.keycode = 16'h162C;
    tick();
    check_eq("sec_y0",   32'(bus.ScreenY), 32'd1);
    check_eq("sec_face", 32'(bus.facing),  32'd0);
    bus.keycode = 16'h0000;
    repeat (15) tick();
    check_eq("sec_y",    32'(bus.ScreenY),   32'd16);
    check_eq("sec_x",    32'(bus.ScreenX),   32'd0);
    check_eq("sec_done", 32'(bus.step_done), 32'd1);

    // key changes mid-step never redirect or abort
    do_reset();
    bus.keycode = 16'h0016;
    repeat (5) tick();
    bus.keycode = 16'h001A;
    repeat (3) tick();
    check_eq("chg_y7", 32'(bus.ScreenY), 32'd8);
    bus.keycode = 16'h0000;
    repeat (8) tick();
    check_eq("chg_y",    32'(bus.ScreenY),   32'd16);
    check_eq("chg_face", 32'(bus.facing),    32'd0);
    check_eq("chg_done", 32'(bus.step_done), 32'd1);
    tick();
    check_eq("chg_idle_y",    32'(bus.ScreenY),   32'd16);
    check_eq("chg_idle_walk", 32'(bus.walking),   32'd0);
    check_eq("chg_idle_done", 32'(bus.step_done), 32'd0);

    // asynchronous reset in the middle of a step
    do_reset();
    bus.keycode = 16'h0007;
    repeat (8) tick();
    check_eq("mid_x7",    32'(bus.ScreenX),    32'd8);
    check_eq("mid_anim7", 32'(bus.anim_frame), 32'd2);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    bus.keycode = 16'h0000;
    repeat (2) tick();
    Reset = 1'b0;
    repeat (5) tick();
    check_reset_vals("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
